// File: rtl/uart_tx_framer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_framer_if
//   Parallel-word handshake between an upstream word source and the UART
//   transmit framer.
//   tx_data  : word to transmit (DATA_WIDTH bits), held by the source until accepted
//   tx_valid : source has a word available
//   tx_ready : framer is idle and will accept the word on the next clk edge
//   master   : word source side
//   slave    : framer side
// ---------------------------------------------------------------------------
interface uart_tx_framer_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
//   UART transmit framer. Takes one parallel word per valid/ready handshake
//   and shifts it out LSB-first as: start bit, DATA_WIDTH data bits, optional
//   parity bit, STOP_BITS stop bits. The line idles high.
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active-low (drops any frame in flight)
//   bus   : handshake (tx_data / tx_valid in, tx_ready out)
//   tx    : serial line, driven straight from a flop
//   busy  : a frame is in progress (complement of tx_ready)
// ---------------------------------------------------------------------------
module uart_tx_framer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_WIDTH   = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_tx_framer_if.slave bus,
   output logic            tx,
   output logic            busy
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state_r;
   state_t                state_next_s;
   logic [BAUD_W-1:0]     baud_cnt_r;
   logic [BIT_W-1:0]      bit_cnt_r;
   logic [DATA_WIDTH-1:0] data_r;
   logic [DATA_WIDTH-1:0] data_next_s;
   logic                  parity_r;
   logic                  tx_r;
   logic                  tx_s;
   logic                  ready_r;
   logic                  ready_s;
   logic                  busy_r;
   logic                  bit_end_s;
   logic                  accept_s;

   // Parity of a whole word: even -> XOR of the bits, odd -> its complement.
   function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] word);
      if (PARITY_ODD != 0) begin
         parity_bit = ~^word;
      end else begin
         parity_bit = ^word;
      end
   endfunction

   // ready_r is a pure decode of the registered state, so accept has no
   // combinational dependence beyond tx_valid AND a flop.
   assign accept_s  = bus.tx_valid & ready_r;
   assign bit_end_s = (baud_cnt_r == BAUD_LAST);

   assign bus.tx_ready = ready_r;
   assign tx           = tx_r;
   assign busy         = busy_r;

   // State register plus the registered line and handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         tx_r    <= 1'b1;
         ready_r <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         tx_r    <= tx_s;
         ready_r <= ready_s;
         busy_r  <= ~ready_s;
      end
   end

   // Baud counter, bit/stop counter, shift register and latched parity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt_r <= {BAUD_W{1'b0}};
         bit_cnt_r  <= {BIT_W{1'b0}};
         data_r     <= {DATA_WIDTH{1'b0}};
         parity_r   <= 1'b0;
      end else begin
         if ((state_r == S_IDLE) || bit_end_s) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
         end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
         end
         // bit_cnt counts data bits in DATA and stop bits in STOP; every
         // state change restarts it.
         if (state_next_s != state_r) begin
            bit_cnt_r <= {BIT_W{1'b0}};
         end else if (bit_end_s && ((state_r == S_DATA) || (state_r == S_STOP))) begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
         end else begin
            bit_cnt_r <= bit_cnt_r;
         end
         data_r <= data_next_s;
         // Parity comes from the word as accepted, since data_r is shifted away.
         if (accept_s) begin
            parity_r <= parity_bit(bus.tx_data);
         end else begin
            parity_r <= parity_r;
         end
      end
   end

   // Next-state and next shift-register contents.
   always_comb begin
      state_next_s = state_r;
      data_next_s  = data_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               state_next_s = S_START;
               data_next_s  = bus.tx_data;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_START: begin
            if (bit_end_s) begin
               state_next_s = S_DATA;
            end else begin
               state_next_s = S_START;
            end
         end
         S_DATA: begin
            if (bit_end_s) begin
               data_next_s = {1'b0, data_r[DATA_WIDTH-1:1]};
               if (bit_cnt_r == DATA_LAST) begin
                  state_next_s = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  state_next_s = S_DATA;
               end
            end else begin
               state_next_s = S_DATA;
            end
         end
         S_PARITY: begin
            if (bit_end_s) begin
               state_next_s = S_STOP;
            end else begin
               state_next_s = S_PARITY;
            end
         end
         S_STOP: begin
            if (bit_end_s && (bit_cnt_r == STOP_LAST)) begin
               state_next_s = S_IDLE;
            end else begin
               state_next_s = S_STOP;
            end
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state, so tx/tx_ready flops line up with state_r.
   always_comb begin
      tx_s    = 1'b1;
      ready_s = 1'b0;
      case (state_next_s)
         S_IDLE: begin
            tx_s    = 1'b1;
            ready_s = 1'b1;
         end
         S_START: begin
            tx_s = 1'b0;
         end
         S_DATA: begin
            tx_s = data_next_s[0];
         end
         S_PARITY: begin
            tx_s = parity_r;
         end
         S_STOP: begin
            tx_s = 1'b1;
         end
         default: begin
            tx_s    = 1'b1;
            ready_s = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_uart_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_framer
//   Four framer instances at CLKS_PER_BIT=4: 8N1, 8E1, 8O1 and 8N2. One
//   shared stimulus source is steered to the selected instance; expected
//   line bits are queued when a word is driven and popped as the line is
//   sampled every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_framer;
   localparam int CPB = 4;
   localparam int DW  = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] tx_data_d = 8'h00;
   logic          tx_valid_d = 1'b0;
   logic [1:0]    cur_sel = 2'd0;
   logic [3:0]    tx_w;
   logic [3:0]    busy_w;
   logic [3:0]    ready_w;
   logic          tx_m;
   logic          ready_m;
   logic          busy_m;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            hs_cyc = 0;
   logic          exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_framer_if #(.DATA_WIDTH(DW)) bus0 ();
   uart_tx_framer_if #(.DATA_WIDTH(DW)) bus1 ();
   uart_tx_framer_if #(.DATA_WIDTH(DW)) bus2 ();
   uart_tx_framer_if #(.DATA_WIDTH(DW)) bus3 ();

   assign bus0.tx_data  = tx_data_d;
   assign bus1.tx_data  = tx_data_d;
   assign bus2.tx_data  = tx_data_d;
   assign bus3.tx_data  = tx_data_d;
   assign bus0.tx_valid = tx_valid_d & (cur_sel == 2'd0);
   assign bus1.tx_valid = tx_valid_d & (cur_sel == 2'd1);
   assign bus2.tx_valid = tx_valid_d & (cur_sel == 2'd2);
   assign bus3.tx_valid = tx_valid_d & (cur_sel == 2'd3);
   assign ready_w = {bus3.tx_ready, bus2.tx_ready, bus1.tx_ready, bus0.tx_ready};
   assign tx_m    = tx_w[cur_sel];
   assign ready_m = ready_w[cur_sel];
   assign busy_m  = busy_w[cur_sel];

   uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0), .tx(tx_w[0]), .busy(busy_w[0]));
   uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .tx(tx_w[1]), .busy(busy_w[1]));
   uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
      dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .tx(tx_w[2]), .busy(busy_w[2]));
   uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
      dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3), .tx(tx_w[3]), .busy(busy_w[3]));

   // Reference frame for instance sel: start, LSB-first data, parity, stops.
   task automatic push_frame(input logic [1:0] sel, input logic [DW-1:0] d);
      exp_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
      if (sel == 2'd1) exp_q.push_back(^d);
      if (sel == 2'd2) exp_q.push_back(~^d);
      exp_q.push_back(1'b1);
      if (sel == 2'd3) exp_q.push_back(1'b1);
   endtask

   task automatic check_idle(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if (tx_m !== 1'b1 || ready_m !== 1'b1 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL %s idle%0d: tx=%b ready=%b busy=%b, want tx=1 ready=1 busy=0",
                     name, i, tx_m, ready_m, busy_m);
         end
      end
   endtask

   // Pops the queued frame, checking the line on every cycle; optional
   // mid-frame stimulus change (disturb) or reset at sample abort_at.
   task automatic check_frame(input string name, input int abort_at, input bit disturb);
      int   idx;
      int   nbits;
      logic b;
      idx   = 0;
      nbits = exp_q.size();
      for (int k = 0; k < nbits; k++) begin
         b = exp_q.pop_front();
         for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            checks++;
            if (tx_m !== b || ready_m !== 1'b0 || busy_m !== 1'b1) begin
               errors++;
               $display("FAIL %s bit%0d cyc%0d: tx=%b ready=%b busy=%b, want tx=%b ready=0 busy=1",
                        name, k, c, tx_m, ready_m, busy_m, b);
            end
            if (disturb && idx == 13) begin
               tx_data_d  = 8'h5A;
               tx_valid_d = 1'b1;
            end
            if (disturb && idx == 14) tx_valid_d = 1'b0;
            if (idx == abort_at) begin
               #2 rst_n = 1'b0;
               #1;
               checks++;
               if (tx_m !== 1'b1 || ready_m !== 1'b1 || busy_m !== 1'b0) begin
                  errors++;
                  $display("FAIL %s async_reset: tx=%b ready=%b busy=%b, want tx=1 ready=1 busy=0",
                           name, tx_m, ready_m, busy_m);
               end
               exp_q.delete();
               return;
            end
            idx++;
         end
      end
      check_idle({name, "_end"}, 1);
   endtask

   // Called in the falling-edge phase; handshake happens on the next usable rising edge.
   task automatic send_frame(input logic [1:0] sel, input logic [DW-1:0] d, input bit keep_valid,
                             input string name, input int abort_at, input bit disturb);
      int w;
      w          = 0;
      cur_sel    = sel;
      tx_data_d  = d;
      tx_valid_d = 1'b1;
      push_frame(sel, d);
      while (ready_m !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (ready_m !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s handshake_timeout: ready=%b, want 1", name, ready_m);
         exp_q.delete();
         tx_valid_d = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      hs_cyc = cyc;
      if (!keep_valid) tx_valid_d = 1'b0;
      check_frame(name, abort_at, disturb);
   endtask

   task automatic test_reset();
      cur_sel    = 2'd0;
      tx_data_d  = 8'hA5;
      tx_valid_d = 1'b1;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tx_w !== 4'hF || ready_w !== 4'hF || busy_w !== 4'h0) begin
         errors++;
         $display("FAIL reset_hold: tx=%b ready=%b busy=%b, want 1111 1111 0000", tx_w, ready_w, busy_w);
      end
      tx_valid_d = 1'b0;
      rst_n      = 1'b1;
      check_idle("reset_release", 5);
   endtask

   task automatic test_8n1();
      @(negedge clk);
      send_frame(2'd0, 8'hA5, 1'b0, "8n1_a5", -1, 1'b0);
      send_frame(2'd0, 8'h01, 1'b0, "8n1_01", -1, 1'b0);
      send_frame(2'd0, 8'h80, 1'b0, "8n1_80", -1, 1'b0);
   endtask

   task automatic test_parity();
      @(negedge clk);
      send_frame(2'd1, 8'hA5, 1'b0, "even_a5", -1, 1'b0);
      send_frame(2'd2, 8'hA5, 1'b0, "odd_a5", -1, 1'b0);
      send_frame(2'd1, 8'h07, 1'b0, "even_07", -1, 1'b0);
      send_frame(2'd2, 8'h07, 1'b0, "odd_07", -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      int t0;
      @(negedge clk);
      send_frame(2'd3, 8'h00, 1'b1, "b2b_00", -1, 1'b0);
      t0 = hs_cyc;
      send_frame(2'd3, 8'hFF, 1'b1, "b2b_ff", -1, 1'b0);
      tx_valid_d = 1'b0;
      checks++;
      if (hs_cyc - t0 !== 45) begin
         errors++;
         $display("FAIL b2b_pitch: got %0d cycles, want 45", hs_cyc - t0);
      end
      check_idle("b2b_after", 4);
   endtask

   task automatic test_mid_frame();
      @(negedge clk);
      send_frame(2'd0, 8'hA5, 1'b0, "midframe", -1, 1'b1);
      check_idle("midframe_after", 6);
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk);
      send_frame(2'd0, 8'h0F, 1'b0, "rst_mid_0f", 4 * CPB + 1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      check_idle("rst_mid_release", 4);
      send_frame(2'd0, 8'h3C, 1'b0, "rst_mid_3c", -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_back_to_back();
      test_mid_frame();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
